// File: rtl/demo_ctrl_debounce_pkg.sv
// Shared constants for the demo control input-conditioning block.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package demo_ctrl_debounce_pkg;

   // Channel bit positions on raw_in / clean_out / changed
   localparam int unsigned CH_START   = 0;
   localparam int unsigned CH_D1_MODE = 1;
   localparam int unsigned CH_D2_MODE = 2;
   localparam int unsigned CH_D1_EN   = 3;
   localparam int unsigned CH_D2_EN   = 4;
   localparam int unsigned CH_DEBUG   = 5;

   localparam int unsigned N_CH_DEFAULT            = 6;
   localparam int unsigned SYNC_STAGES_DEFAULT     = 2;
   // 10 ms of stability at a 50 MHz clock
   localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 500000;
   localparam int unsigned CNT_WIDTH_DEFAULT       = 20;

   // Per-channel qualification state: IDLE while the synchronised level
   // matches the accepted level, COUNTING while it disagrees.
   typedef enum logic {
      DB_IDLE     = 1'b0,
      DB_COUNTING = 1'b1
   } db_state_e;

endpackage

// File: rtl/demo_debounce_ch.sv
// Single-channel synchroniser + stability counter + accepted-level register.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES - 1 edges from first sampling to clean_o.
// Backpressure: none; free-running, one strobe per accepted change.
module demo_debounce_ch
   import demo_ctrl_debounce_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEFAULT,
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter int unsigned CNT_WIDTH       = CNT_WIDTH_DEFAULT,
   parameter bit          RST_VAL         = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_i,
   output logic clean_o,
   output logic changed_o,
   // Combinational: an accepted 1->0 change lands on the next edge
   output logic fell_o
);

   // Last count value before acceptance; the counter is cleared on accept,
   // so it never needs to exceed this value.
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic                   clean_q, clean_d;
   logic                   changed_q, changed_d;
   logic                   sync_lvl;
   db_state_e              state;

   assign sync_lvl = sync_q[SYNC_STAGES-1];

   // Qualify a disagreement between the synchronised and accepted levels
   always_comb begin
      state     = (sync_lvl != clean_q) ? DB_COUNTING : DB_IDLE;
      cnt_d     = '0;
      clean_d   = clean_q;
      changed_d = 1'b0;
      case (state)
         DB_IDLE: begin
            // Any agreement drops partial credit
            cnt_d = '0;
         end
         DB_COUNTING: begin
            if (cnt_q == CNT_LAST) begin
               clean_d   = sync_lvl;
               changed_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_WIDTH'(1);
            end
         end
         default: begin
            cnt_d = '0;
         end
      endcase
   end

   // Synchroniser chain, counter and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q    <= {SYNC_STAGES{RST_VAL}};
         cnt_q     <= '0;
         clean_q   <= RST_VAL;
         changed_q <= 1'b0;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], raw_i};
         cnt_q     <= cnt_d;
         clean_q   <= clean_d;
         changed_q <= changed_d;
      end
   end

   assign clean_o   = clean_q;
   assign changed_o = changed_q;
   assign fell_o    = changed_d & ~clean_d;

endmodule

// File: rtl/demo_ctrl_debounce.sv
// Conditions raw board buttons/switches into clean levels and change strobes.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES - 1 edges from first sampling edge.
// Backpressure: none; outputs are levels and single-cycle strobes.
module demo_ctrl_debounce
   import demo_ctrl_debounce_pkg::*;
#(
   parameter int unsigned      N_CH            = N_CH_DEFAULT,
   parameter int unsigned      SYNC_STAGES     = SYNC_STAGES_DEFAULT,
   parameter int unsigned      DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter int unsigned      CNT_WIDTH       = CNT_WIDTH_DEFAULT,
   // Start (bit 0) idles high because the button is active-low
   parameter logic [N_CH-1:0]  RESET_VAL       = N_CH'(1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] raw_in,
   output logic [N_CH-1:0] clean_out,
   output logic [N_CH-1:0] changed,
   output logic            start_press
);

   logic start_fell;
   logic start_press_q;

   for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
      logic fell;

      demo_debounce_ch #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_WIDTH       (CNT_WIDTH),
         .RST_VAL         (RESET_VAL[i])
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .raw_i     (raw_in[i]),
         .clean_o   (clean_out[i]),
         .changed_o (changed[i]),
         .fell_o    (fell)
      );

      // Only the start channel cares about falling acceptances
      if (i == int'(CH_START)) begin : g_start
         assign start_fell = fell;
      end else begin : g_other
         logic unused_fell;
         assign unused_fell = fell;
      end
   end

   // Press strobe registered on the same edge as the start channel's accept
   always_ff @(posedge clk) begin
      if (rst) begin
         start_press_q <= 1'b0;
      end else begin
         start_press_q <= start_fell;
      end
   end

   assign start_press = start_press_q;

endmodule

// File: tb/tb_demo_ctrl_debounce.sv
// Directed bench for demo_ctrl_debounce with a cycle-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_demo_ctrl_debounce;

   localparam int            NC  = 6;
   localparam int            DEB = 4;
   localparam logic [NC-1:0] RV  = 6'b000001;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NC-1:0] raw_in = 6'b111110;
   logic [NC-1:0] clean_out;
   logic [NC-1:0] changed;
   logic          start_press;

   int n_chk  = 0;
   int n_pass = 0;

   demo_ctrl_debounce #(
      .N_CH            (NC),
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (DEB),
      .CNT_WIDTH       (20),
      .RESET_VAL       (RV)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .raw_in      (raw_in),
      .clean_out   (clean_out),
      .changed     (changed),
      .start_press (start_press)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
   endtask

   // Reference model: a level is accepted once the synchronised input has
   // shown the same new value for DEB whole cycles in a row.
   logic [NC-1:0] m_st1, m_sync, m_clean, m_chg;
   logic          m_sp;
   logic [NC-1:0] m_hist [DEB];
   bit            m_live = 0;

   always @(posedge clk) begin
      if (rst) begin
         m_st1   = RV;
         m_sync  = RV;
         m_clean = RV;
         m_chg   = '0;
         m_sp    = 1'b0;
         for (int j = 0; j < DEB; j++) m_hist[j] = RV;
      end else begin
         for (int j = DEB - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
         m_hist[0] = m_sync;
         m_chg = '0;
         for (int b = 0; b < NC; b++) begin
            bit stable;
            stable = 1'b1;
            for (int j = 0; j < DEB; j++)
               if (m_hist[j][b] != m_hist[0][b]) stable = 1'b0;
            if (stable && (m_hist[0][b] != m_clean[b])) begin
               m_clean[b] = m_hist[0][b];
               m_chg[b]   = 1'b1;
            end
         end
         m_sp   = m_chg[0] && !m_clean[0];
         m_sync = m_st1;
         m_st1  = raw_in;
      end
      m_live = 1;
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      if (m_live) begin
         chk("model_clean", clean_out, m_clean);
         chk("model_changed", changed, m_chg);
         chk("model_start_press", start_press, m_sp);
      end
   end

   initial begin
      int first;
      int nstr;

      // Reset held 3 cycles with non-idle inputs
      rst    = 1'b1;
      raw_in = 6'b111110;
      repeat (3) begin
         @(negedge clk);
         chk("rst_clean", clean_out, 6'b000001);
         chk("rst_changed", changed, 6'b000000);
         chk("rst_sp", start_press, 0);
      end
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_clean", clean_out, 6'b000001);
      chk("post_rst_changed", changed, 6'b000000);
      chk("post_rst_sp", start_press, 0);
      raw_in = 6'b000001;
      repeat (10) @(negedge clk);
      chk("idle_clean", clean_out, 6'b000001);

      // Clean press on start
      raw_in[0] = 1'b0;
      first = 0;
      nstr  = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (changed != 0) begin
            nstr++;
            if (first == 0) first = k;
         end
         if (k == 5) chk("press_pre_clean", clean_out[0], 1);
         if (k == 6) begin
            chk("press_clean", clean_out, 6'b000000);
            chk("press_changed", changed, 6'b000001);
            chk("press_sp", start_press, 1);
         end
         if (k == 7) begin
            chk("press_changed_gone", changed, 6'b000000);
            chk("press_sp_gone", start_press, 0);
         end
      end
      chk("press_first_strobe", first, 6);
      chk("press_strobe_count", nstr, 1);

      // Release start: a change strobe but no press strobe
      raw_in[0] = 1'b1;
      repeat (20) @(negedge clk);
      chk("release_clean", clean_out, 6'b000001);

      // Bounce on d1_en, finishing high
      nstr = 0;
      for (int j = 0; j < 8; j++) begin
         raw_in[3] = (j % 2 == 1);
         if (j < 7) begin
            @(negedge clk);
            if (changed[3]) nstr++;
         end
      end
      first = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (changed[3]) begin
            nstr++;
            if (first == 0) first = k;
         end
      end
      chk("bounce_first_strobe", first, 6);
      chk("bounce_strobe_count", nstr, 1);
      chk("bounce_clean", clean_out, 6'b001001);

      // Three-cycle glitch on start is rejected
      nstr = 0;
      raw_in[0] = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (changed != 0 || start_press) nstr++;
      end
      raw_in[0] = 1'b1;
      repeat (12) begin
         @(negedge clk);
         if (changed != 0 || start_press) nstr++;
      end
      chk("glitch_strobes", nstr, 0);
      chk("glitch_clean", clean_out, 6'b001001);

      // Two channels rising together
      raw_in[1] = 1'b1;
      raw_in[4] = 1'b1;
      first = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (changed != 0 && first == 0) first = k;
         if (k == 6) begin
            chk("simul_changed", changed, 6'b010010);
            chk("simul_sp", start_press, 0);
         end
      end
      chk("simul_first_strobe", first, 6);
      chk("simul_clean", clean_out, 6'b011011);

      // Reset while debug is mid-qualification
      raw_in[5] = 1'b1;
      nstr = 0;
      repeat (2) begin
         @(negedge clk);
         if (changed != 0) nstr++;
      end
      rst = 1'b1;
      repeat (2) begin
         @(negedge clk);
         if (changed != 0) nstr++;
      end
      chk("midrst_no_strobe", nstr, 0);
      chk("midrst_clean_in_rst", clean_out, 6'b000001);
      rst = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 5) begin
            chk("requal_pre_debug", clean_out[5], 0);
            chk("requal_pre_changed", changed, 6'b000000);
         end
         if (k == 6) begin
            chk("requal_clean", clean_out, 6'b111011);
            chk("requal_changed", changed, 6'b111010);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
